// File: rtl/bcd2bin_if.sv
// Handshake and data bundle between the keypad entry logic (master) and the
// BCD-to-binary converter (slave).
interface bcd2bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    logic                  ovf;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err, ovf
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err, ovf
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, most significant
// digit first, with start/busy/done handshake and invalid-digit / range flags.
module bcd2bin_seq #(
    parameter int DIGITS  = 3,
    parameter int BIN_W   = 10,
    parameter int MAX_VAL = 127
) (
    input  logic      clk,
    input  logic      res_n,
    bcd2bin_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONV    = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]          state;
    logic [4*DIGITS-1:0] digits_q;
    logic [IDX_W-1:0]    idx;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [3:0]          cur_digit;
    logic                any_bad;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                ovf_q;
    logic [BIN_W-1:0]    bin_q;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) any_bad = 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) cur_digit = digits_q[4*i +: 4];
        end
    end

    // acc*10 as shift-and-add; BIN_W is wide enough that no bits are lost.
    assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(cur_digit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            // NOTE: the digit register is reset too, so an abandoned conversion
            // leaves no stale operand behind.
            state    <= IDLE;
            digits_q <= '0;
            idx      <= '0;
            acc      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            bin_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    if (bus.start) begin
                        digits_q <= bus.bcd_in;
                        if (any_bad) begin
                            state  <= DONE_ST;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            ovf_q  <= 1'b0;
                            bin_q  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= CONV;
                            acc    <= '0;
                            idx    <= IDX_W'(DIGITS - 1);
                            busy_q <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    idx <= idx - IDX_W'(1);
                    if (idx == '0) begin
                        state  <= DONE_ST;
                        bin_q  <= acc_next;
                        ovf_q  <= (acc_next > MAX_BIN);
                        err_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.ovf     = ovf_q;
    assign bus.bin_out = bin_q;
endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter: the input-side counterpart of the calculator's binary-to-BCD display path.
- Accepts a packed multi-digit BCD operand from the keypad/switch entry logic and produces the binary value for the arithmetic unit.
- Converts one digit per clock, most significant digit first (acc = acc*10 + digit).
- Start/busy/done handshake; flags invalid digits and operand range overflow.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in.
- BIN_W, 10, binary output width; must satisfy 2^BIN_W > 10^DIGITS - 1.
- MAX_VAL, 127, largest legal operand for the arithmetic unit; larger results raise ovf.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- res_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled on the rising edge.
- bcd_in  input  4*DIGITS  packed BCD; bits [3:0] are the least significant digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; result and flags are valid in that cycle.
- bin_out  output  BIN_W  converted binary value; holds until the next done.
- err  output  1  last conversion had a digit > 9; valid with done, held until the next done.
- ovf  output  1  last result > MAX_VAL; valid with done, held until the next done.

Behaviour:
- Reset (res_n=0, asynchronous): state=IDLE; busy, done, err and ovf =0; bin_out=0; internal acc, index and digit register =0.
- States:
  - IDLE: waiting for start.
  - CONV: one digit accumulated per edge.
  - DONE: one-cycle result strobe.
- IDLE + start=1 at edge E:
  - Register bcd_in and check all digits.
  - If any digit > 9: go to DONE. After edge E, done=1, err=1, ovf=0, bin_out=0, busy=0.
  - Otherwise: acc=0, idx=DIGITS-1, go to CONV. busy=1 from after edge E.
- CONV, each edge:
  - acc <= acc*10 + digit[idx]; idx <= idx-1.
  - The *10 is computed as (acc<<3)+(acc<<1) at BIN_W bits; no truncation can occur given the BIN_W constraint.
  - On the edge that consumes digit[0] (edge E+DIGITS): go to DONE, with bin_out <= final acc, ovf <= (final acc > MAX_VAL), err <= 0, busy <= 0, done <= 1.
- Latency: valid conversion gives done exactly DIGITS cycles after the start-capturing edge. Invalid input gives done 1 cycle after it.
- DONE lasts exactly one cycle:
  - Next edge returns to IDLE with done <= 0.
  - If start=1 on that same edge, a new conversion is accepted directly (state goes to CONV or DONE as for IDLE), and done <= 0 for the new operation.
- start while in CONV: ignored. No queuing, no abort; bcd_in changes during CONV have no effect because the digits are registered.
- start held high continuously: one conversion is accepted per DONE/IDLE visit, giving back-to-back conversions every DIGITS+1 cycles.
- bin_out, err and ovf change only on the edge that raises done (or on reset).
- Reset asserted mid-CONV: conversion abandoned, all outputs 0 immediately, no done pulse; the first start after deassertion behaves normally.
- All-zero input (0x000): bin_out=0, done after DIGITS cycles, err=0, ovf=0.

Test Plan:
- Reset: hold res_n=0 with start toggling -> busy=done=err=ovf=0, bin_out=0. Release -> stays IDLE until start.
- bcd_in=0x127, start for 1 cycle at edge E -> busy=1 over edges E+1..E+2. After E+3: done=1 (1 cycle), bin_out=127, ovf=0, err=0. bin_out still 127 ten cycles later.
- bcd_in=0x999 -> bin_out=999 (0x3E7), ovf=1, err=0 after 3 cycles. Follow with 0x128 -> bin_out=128, ovf=1. Follow with 0x000 -> bin_out=0, ovf=0.
- bcd_in=0x1A3 -> done=1 one cycle after start, err=1, bin_out=0, ovf=0, busy never high.
- Start 0x042, then pulse start with bcd_in=0x055 at edges E+1 and E+2 -> ignored, result 42. Then assert start=1 with 0x055 during the done cycle -> accepted, done again 3 cycles later with bin_out=55.
- Start 0x127, assert res_n=0 after edge E+2 -> outputs 0 at once, no done. Release, start 0x063 -> bin_out=63 after 3 cycles.
